// File: rtl/dcache_mem_stage.sv
// Memory-stage data cache: direct-mapped, one word per line, write-through, no-write-allocate.
// Optional hit/miss statistics counters are enabled with the DCACHE_STATS_EN macro.
module dcache_mem_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_BITS    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     memreadm,
  input  logic                     memwritem,
  input  logic [2:0]               funct3m,
  input  logic [ADDRESS_WIDTH-1:0] aluresultm,
  input  logic [DATA_WIDTH-1:0]    writedatam,
  output logic [DATA_WIDTH-1:0]    readdatam,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDRESS_WIDTH - 2 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_BITS-1:0]     tag_arr  [LINES];
  logic [DATA_WIDTH-1:0]   data_arr [LINES];
  logic                    wr_hit;

  logic [INDEX_BITS-1:0]   idx, fill_idx;
  logic [TAG_BITS-1:0]     tag, fill_tag;
  logic                    hit, is_load;
  logic [1:0]              off;
  logic [DATA_WIDTH-1:0]   raw_word, ext_data, st_data, merged;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [3:0]              st_be;
  logic                    stall_c;

  assign idx      = aluresultm[INDEX_BITS+1:2];
  assign tag      = aluresultm[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign off      = aluresultm[1:0];
  // Refill/merge target comes from the registered request, not the live inputs.
  assign fill_idx = mem_addr[INDEX_BITS+1:2];
  assign fill_tag = mem_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];

  assign hit      = valid[idx] && (tag_arr[idx] == tag);
  assign is_load  = memreadm && !memwritem;
  assign raw_word = data_arr[idx];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ext_data = raw_word;
    byte_sel = 8'(raw_word >> {off, 3'b000});
    half_sel = off[1] ? raw_word[31:16] : raw_word[15:0];
    case (funct3m)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'b0, byte_sel};
      3'b101:  ext_data = {16'b0, half_sel};
      default: ext_data = raw_word;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = writedatam;
    case (funct3m)
      3'b000: begin
        st_be   = 4'b0001 << off;
        st_data = {4{writedatam[7:0]}};
      end
      3'b001: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{writedatam[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = writedatam;
      end
    endcase
  end

  always_comb begin
    merged = data_arr[fill_idx];
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) merged[8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    stall_c = 1'b0;
    case (state)
      IDLE:             stall_c = memwritem || (memreadm && !hit);
      RD_WAIT, WR_WAIT: stall_c = 1'b1;
      DONE:             stall_c = 1'b0;
      default:          stall_c = 1'b0;
    endcase
  end

  assign stall     = rst_n && stall_c;
  assign readdatam = rst_n ? ext_data : '0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      wr_hit    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memwritem) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {aluresultm[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wdata <= st_data;
            mem_be    <= st_be;
            wr_hit    <= hit;
            state     <= WR_WAIT;
          end else if (memreadm && !hit) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {aluresultm[ADDRESS_WIDTH-1:2], 2'b00};
            mem_be    <= 4'b1111;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            mem_req         <= 1'b0;
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays are plain storage without reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == RD_WAIT && mem_ack) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_rdata;
    end else if (state == WR_WAIT && mem_ack && wr_hit) begin
      data_arr[fill_idx] <= merged;
    end
  end

`ifdef DCACHE_STATS_EN
  // The replayed load right after a refill is not a new hit.
  logic refill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      refill     <= 1'b0;
    end else begin
      refill <= (state == RD_WAIT) && mem_ack;
      if (state == IDLE && is_load && hit && !refill && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (state == IDLE && is_load && !hit && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
